// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through and runs loads/stores as a
// multi-cycle request/ack handshake on the data bus, stalling the pipeline meanwhile.
module mem_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_stall,
  input  logic [4:0]  i_ex_wd,
  input  logic        i_ex_wreg,
  input  logic [31:0] i_ex_wdata,
  input  logic [7:0]  i_ex_aluop,
  input  logic [31:0] i_ex_mem_addr,
  input  logic [31:0] i_ex_reg2,
  output logic [4:0]  o_mem_wd,
  output logic        o_mem_wreg,
  output logic [31:0] o_mem_wdata,
  output logic        o_stallreq,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [3:0]  o_dbus_sel,
  output logic [31:0] o_dbus_wdata,
  input  logic [31:0] i_dbus_rdata,
  input  logic        i_dbus_ack,
  output logic        o_mem_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam bit TMO_EN = (MAX_WAIT > 0);
  localparam logic [CW-1:0] LIMIT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_abort;
  logic [31:0]   r_rdata;
  logic [7:0]    r_op;
  logic [1:0]    r_lo;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          w_is_mem;
  logic          w_is_store;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_fmt;
  logic          w_timeout;
  logic          w_unused;

  assign w_unused = ^{i_stall[5], i_stall[3:0]};

  // Decode the incoming op into bus lane enables and lane-replicated store data.
  always_comb begin
    w_is_mem   = 1'b1;
    w_is_store = 1'b0;
    w_sel      = 4'b0000;
    w_wdata    = 32'h0;
    case (i_ex_aluop)
      EXE_LB_OP, EXE_LBU_OP: w_sel = 4'b1000 >> i_ex_mem_addr[1:0];
      EXE_LH_OP, EXE_LHU_OP: w_sel = i_ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP:             w_sel = 4'b1111;
      EXE_SB_OP: begin
        w_is_store = 1'b1;
        w_sel      = 4'b1000 >> i_ex_mem_addr[1:0];
        w_wdata    = {4{i_ex_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        w_is_store = 1'b1;
        w_sel      = i_ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata    = {2{i_ex_reg2[15:0]}};
      end
      EXE_SW_OP: begin
        w_is_store = 1'b1;
        w_sel      = 4'b1111;
        w_wdata    = i_ex_reg2;
      end
      default: w_is_mem = 1'b0;
    endcase
  end

  // Big-endian lane extraction uses the op and address captured at request time.
  always_comb begin
    w_byte = 8'h0;
    case (r_lo)
      2'd0: w_byte = i_dbus_rdata[31:24];
      2'd1: w_byte = i_dbus_rdata[23:16];
      2'd2: w_byte = i_dbus_rdata[15:8];
      default: w_byte = i_dbus_rdata[7:0];
    endcase
    w_half = r_lo[1] ? i_dbus_rdata[15:0] : i_dbus_rdata[31:16];
    w_fmt  = 32'h0;
    case (r_op)
      EXE_LB_OP:  w_fmt = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: w_fmt = {24'h0, w_byte};
      EXE_LH_OP:  w_fmt = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: w_fmt = {16'h0, w_half};
      EXE_LW_OP:  w_fmt = i_dbus_rdata;
      default:    w_fmt = 32'h0;
    endcase
  end

  assign w_timeout = TMO_EN && (r_cnt == LIMIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_rdata <= 32'h0;
      r_op    <= 8'h0;
      r_lo    <= 2'b00;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_sel   <= 4'b0000;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_is_mem) begin
            r_state <= BUSY;
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {i_ex_mem_addr[31:2], 2'b00};
            r_sel   <= w_sel;
            r_wdata <= w_wdata;
            r_op    <= i_ex_aluop;
            r_lo    <= i_ex_mem_addr[1:0];
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_rdata <= 32'h0;
          end
        end
        BUSY: begin
          // An ack in the timeout cycle still completes the access normally.
          if (i_dbus_ack) begin
            r_rdata <= w_fmt;
            r_req   <= 1'b0;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_abort <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (!i_stall[4]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with reset lets the stall request fall together with the bus request.
  always_comb begin
    o_mem_wd    = i_ex_wd;
    o_mem_wreg  = i_ex_wreg;
    o_mem_wdata = i_ex_wdata;
    o_stallreq  = ~i_rst & ((r_state == BUSY) || ((r_state == IDLE) && w_is_mem));
    if (r_state == DONE) begin
      o_mem_wreg  = i_ex_wreg & ~r_abort & ~w_is_store;
      o_mem_wdata = r_rdata;
    end else if (w_is_mem) begin
      o_mem_wreg  = 1'b0;
      o_mem_wdata = 32'h0;
    end
  end

  assign o_dbus_req   = r_req;
  assign o_dbus_we    = r_we;
  assign o_dbus_addr  = r_addr;
  assign o_dbus_sel   = r_sel;
  assign o_dbus_wdata = r_wdata;
  assign o_mem_err    = r_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: two instances (default timeout and MAX_WAIT=3) share stimulus
// and are checked cycle by cycle against a lane-level model of the load/store rules.
module tb_mem_lsu;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam int MAXW_A = 255;
  localparam int MAXW_B = 3;
  localparam int NO_ACK = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  exWd;
  logic        exWreg;
  logic [31:0] exWdata;
  logic [7:0]  exAluop;
  logic [31:0] exMemAddr;
  logic [31:0] exReg2;
  logic [31:0] dbusRdata;
  logic        dbusAck;

  logic [4:0]  memWd [2];
  logic        memWreg [2];
  logic [31:0] memWdata [2];
  logic        stallreq [2];
  logic        dbusReq [2];
  logic        dbusWe [2];
  logic [31:0] dbusAddr [2];
  logic [3:0]  dbusSel [2];
  logic [31:0] dbusWdata [2];
  logic        memErr [2];

  int checkCount = 0;
  int passCount = 0;

  logic [7:0]  curOp;
  logic [31:0] curAddr, curReg2, curRdata;
  logic [4:0]  curWd;
  logic        curWreg;
  int          expBusy [2];
  bit          expTimeout [2];
  logic [31:0] expData [2];
  logic        expWreg [2];

  logic [7:0] memOps [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                             EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

  always #5 clk = ~clk;

  mem_lsu #(.MAX_WAIT(MAXW_A)) dutA (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_ex_wd(exWd), .i_ex_wreg(exWreg),
    .i_ex_wdata(exWdata), .i_ex_aluop(exAluop), .i_ex_mem_addr(exMemAddr), .i_ex_reg2(exReg2),
    .o_mem_wd(memWd[0]), .o_mem_wreg(memWreg[0]), .o_mem_wdata(memWdata[0]),
    .o_stallreq(stallreq[0]), .o_dbus_req(dbusReq[0]), .o_dbus_we(dbusWe[0]),
    .o_dbus_addr(dbusAddr[0]), .o_dbus_sel(dbusSel[0]), .o_dbus_wdata(dbusWdata[0]),
    .i_dbus_rdata(dbusRdata), .i_dbus_ack(dbusAck), .o_mem_err(memErr[0])
  );

  mem_lsu #(.MAX_WAIT(MAXW_B)) dutB (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_ex_wd(exWd), .i_ex_wreg(exWreg),
    .i_ex_wdata(exWdata), .i_ex_aluop(exAluop), .i_ex_mem_addr(exMemAddr), .i_ex_reg2(exReg2),
    .o_mem_wd(memWd[1]), .o_mem_wreg(memWreg[1]), .o_mem_wdata(memWdata[1]),
    .o_stallreq(stallreq[1]), .o_dbus_req(dbusReq[1]), .o_dbus_we(dbusWe[1]),
    .o_dbus_addr(dbusAddr[1]), .o_dbus_sel(dbusSel[1]), .o_dbus_wdata(dbusWdata[1]),
    .i_dbus_rdata(dbusRdata), .i_dbus_ack(dbusAck), .o_mem_err(memErr[1])
  );

  // Single comparison point: every check is counted here and mismatches reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Access size in bytes; zero marks a non-memory op.
  function automatic int opSize(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit isStore(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // First big-endian byte lane touched by the access.
  function automatic int firstLane(input logic [7:0] op, input logic [31:0] addr);
    int size = opSize(op);
    if (size == 1) return int'(addr[1:0]);
    if (size == 2) return addr[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] modelSel(input logic [7:0] op, input logic [31:0] addr);
    logic [3:0] s = 4'b0000;
    int first = firstLane(op, addr);
    for (int lane = first; lane < first + opSize(op); lane++) s[3 - lane] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] modelStoreData(input logic [7:0] op, input logic [31:0] reg2);
    logic [31:0] v = 32'h0;
    int size = opSize(op);
    for (int b = 0; b < 4; b++) v[8*b +: 8] = reg2[8*(b % size) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    int size = opSize(op);
    int first = firstLane(op, addr);
    logic [31:0] v, mask;
    v = rdata >> (8 * (4 - first - size));
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [7:0] randomAluOp();
    logic [7:0] op = 8'($urandom);
    for (int t = 0; t < 10 && opSize(op) != 0; t++) op = 8'($urandom);
    if (opSize(op) != 0) op = 8'h00;
    return op;
  endfunction

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    exAluop = op; exMemAddr = addr; exReg2 = reg2; exWd = wd; exWreg = wreg; exWdata = wdata;
    curOp = op; curAddr = addr; curReg2 = reg2; curWd = wd; curWreg = wreg;
  endtask

  // k = -1 is the IDLE cycle carrying the op; k >= 0 counts cycles after that.
  task automatic checkCycle(input int k);
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "A." : "B.";
      if (k < 0) begin
        checkOutput({p, "idleStallreq"}, 32'(stallreq[i]), 32'd1);
        checkOutput({p, "idleReq"}, 32'(dbusReq[i]), 32'd0);
      end else if (k < expBusy[i]) begin
        checkOutput({p, "busyStallreq"}, 32'(stallreq[i]), 32'd1);
        checkOutput({p, "busyReq"}, 32'(dbusReq[i]), 32'd1);
        checkOutput({p, "busyErr"}, 32'(memErr[i]), 32'd0);
        if (k == 0) begin
          checkOutput({p, "addr"}, dbusAddr[i], curAddr & 32'hFFFF_FFFC);
          checkOutput({p, "sel"}, 32'(dbusSel[i]), 32'(modelSel(curOp, curAddr)));
          checkOutput({p, "we"}, 32'(dbusWe[i]), 32'(isStore(curOp)));
          if (isStore(curOp)) checkOutput({p, "wdata"}, dbusWdata[i], modelStoreData(curOp, curReg2));
        end
      end else begin
        checkOutput({p, "doneStallreq"}, 32'(stallreq[i]), 32'd0);
        checkOutput({p, "doneReq"}, 32'(dbusReq[i]), 32'd0);
        checkOutput({p, "doneErr"}, 32'(memErr[i]), 32'((k == expBusy[i]) && expTimeout[i]));
        checkOutput({p, "doneWreg"}, 32'(memWreg[i]), 32'(expWreg[i]));
        checkOutput({p, "doneWd"}, 32'(memWd[i]), 32'(curWd));
        if (!expTimeout[i] && !isStore(curOp)) checkOutput({p, "loadData"}, memWdata[i], expData[i]);
      end
    end
  endtask

  task automatic runMemOp(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                          input int ackDelay, input int hold);
    int maxw, maxBusy, total;
    @(negedge clk);
    applyStimulus(op, addr, reg2, wd, wreg, $urandom);
    curRdata = rdata;
    stall = 6'b011111;
    dbusAck = 1'($urandom_range(0, 1));
    dbusRdata = $urandom;
    maxBusy = 0;
    for (int i = 0; i < 2; i++) begin
      maxw = (i == 0) ? MAXW_A : MAXW_B;
      expTimeout[i] = (ackDelay >= maxw);
      expBusy[i] = expTimeout[i] ? maxw : ackDelay + 1;
      expData[i] = modelLoad(op, addr, rdata);
      expWreg[i] = wreg & !expTimeout[i] & !isStore(op);
      if (expBusy[i] > maxBusy) maxBusy = expBusy[i];
    end
    #1 checkCycle(-1);
    total = maxBusy + 1 + hold;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      dbusAck = (k == ackDelay) || ((k >= maxBusy) && ($urandom_range(0, 1) == 1));
      dbusRdata = (k == ackDelay) ? curRdata : $urandom;
      #1 checkCycle(k);
    end
    @(negedge clk);
    stall = 6'b000000;
    dbusAck = 1'b0;
    #1 checkCycle(total);
  endtask

  task automatic runAluOp(input logic [7:0] op, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    @(negedge clk);
    applyStimulus(op, $urandom, $urandom, wd, wreg, wdata);
    stall = 6'b000000;
    dbusAck = 1'($urandom_range(0, 1));
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("aluWd", 32'(memWd[i]), 32'(wd));
      checkOutput("aluWreg", 32'(memWreg[i]), 32'(wreg));
      checkOutput("aluWdata", memWdata[i], wdata);
      checkOutput("aluStallreq", 32'(stallreq[i]), 32'd0);
      checkOutput("aluReq", 32'(dbusReq[i]), 32'd0);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) checkOutput("aluReqLater", 32'(dbusReq[i]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; dbusAck = 1'b0; dbusRdata = 32'h0;
    applyStimulus(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rstWdata", memWdata[i], 32'h0);
      checkOutput("rstWreg", 32'(memWreg[i]), 32'd0);
      checkOutput("rstStallreq", 32'(stallreq[i]), 32'd0);
      checkOutput("rstReq", 32'(dbusReq[i]), 32'd0);
      checkOutput("rstWe", 32'(dbusWe[i]), 32'd0);
      checkOutput("rstErr", 32'(memErr[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    runAluOp(8'h21, 5'd5, 1'b1, 32'h0000_1234);
    runMemOp(EXE_LB_OP,  32'h0000_0101, 32'h0, 5'd3, 1'b1, 32'h11F2_3344, 0, 0);
    checkOutput("lbConst", expData[0], 32'hFFFF_FFF2);
    runMemOp(EXE_LBU_OP, 32'h0000_0101, 32'h0, 5'd3, 1'b1, 32'h11F2_3344, 0, 0);
    checkOutput("lbuConst", expData[0], 32'h0000_00F2);
    runMemOp(EXE_SH_OP,  32'h0000_0202, 32'hABCD_BEEF, 5'd0, 1'b1, 32'h0, 1, 1);
    runMemOp(EXE_LW_OP,  32'h0000_0300, 32'h0, 5'd7, 1'b1, 32'hCAFE_F00D, 4, 2);
    runMemOp(EXE_LH_OP,  32'h0000_0402, 32'h0, 5'd9, 1'b1, 32'h1234_8001, 2, 0);
    runMemOp(EXE_LW_OP,  32'h0000_0500, 32'h0, 5'd4, 1'b1, 32'h5555_AAAA, NO_ACK, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        runAluOp(randomAluOp(), 5'($urandom), 1'($urandom), $urandom);
      else
        runMemOp(memOps[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom), 1'($urandom),
                 $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Reset dropped into the middle of a BUSY access.
    @(negedge clk);
    applyStimulus(EXE_LW_OP, 32'h0000_0600, 32'h0, 5'd2, 1'b1, 32'h0);
    stall = 6'b011111; dbusAck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("midRstReq", 32'(dbusReq[i]), 32'd0);
      checkOutput("midRstStallreq", 32'(stallreq[i]), 32'd0);
    end
    @(negedge clk);
    applyStimulus(8'h25, 32'h0, 32'h0, 5'd11, 1'b1, 32'h00C0_FFEE);
    stall = 6'b000000;
    #1 rst = 1'b0;
    dbusAck = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("postRstWdata", memWdata[i], 32'h00C0_FFEE);
      checkOutput("postRstWreg", 32'(memWreg[i]), 32'd1);
      checkOutput("postRstStallreq", 32'(stallreq[i]), 32'd0);
    end
    @(negedge clk);
    dbusAck = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) checkOutput("postRstReq", 32'(dbusReq[i]), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
